// File: rtl/keccak_arb_pkg.sv
// Shared types and constants for the keccak core arbiter.
// The optional ownership watchdog is enabled by defining KECCAK_ARB_WDOG_EN.
package keccak_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        OWN,
        FLUSH
    } arb_state_t;

    localparam logic [1:0] SHA3_256 = 2'd0;
    localparam logic [1:0] SHA3_512 = 2'd1;
    localparam logic [1:0] SHAKE128 = 2'd2;
    localparam logic [1:0] SHAKE256 = 2'd3;

    localparam int WORDS_SHA3_256 = 4;
    localparam int WORDS_SHA3_512 = 8;
    localparam int WORDS_SHAKE128 = 21;
    localparam int WORDS_SHAKE256 = 17;

    // Number of output words the core produces per squeeze block for a mode
    function automatic int out_words(input logic [1:0] mode);
        case (mode)
            SHA3_256: return WORDS_SHA3_256;
            SHA3_512: return WORDS_SHA3_512;
            SHAKE128: return WORDS_SHAKE128;
            default:  return WORDS_SHAKE256;
        endcase
    endfunction

endpackage

// File: rtl/keccak_arbiter_rr_arbiter.sv
// Combinational round-robin winner select: first set req bit strictly after ptr,
// wrapping around. Reports the winner both one-hot and as an index.
module rr_arbiter
    import keccak_arb_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] win_onehot,
    output logic [IW-1:0]   win_idx,
    output logic            win_any
);

    logic [IW-1:0] pos;

    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        win_any    = 1'b0;
        pos        = '0;
        for (int i = 1; i <= NREQ; i++) begin
            pos = IW'((int'(ptr) + i) % NREQ);
            if (!win_any && req[pos]) begin
                win_any         = 1'b1;
                win_onehot[pos] = 1'b1;
                win_idx         = pos;
            end
        end
    end

endmodule

// File: rtl/keccak_arbiter.sv
// Shares one keccak core among NREQ requesters with round-robin ownership.
// Define KECCAK_ARB_WDOG_EN to add a stall watchdog and the wdog_err output.
module keccak_arbiter
    import keccak_arb_pkg::*;
#(
    parameter int NREQ        = 3,
    parameter int DW          = 64,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_release,
    input  logic [2*NREQ-1:0]    req_mode,
    input  logic [DW*NREQ-1:0]   req_in,
    input  logic [NREQ-1:0]      req_in_valid,
    input  logic [NREQ-1:0]      req_is_last,
    input  logic [NREQ-1:0]      req_gimme,
    output logic [NREQ-1:0]      grant,
    output logic [NREQ-1:0]      req_ack,
    output logic [NREQ-1:0]      req_out_valid,
    output logic [DW-1:0]        req_out,
    output logic                 busy,
    output logic                 k_start_calc,
    output logic                 k_in_valid,
    output logic                 k_is_last,
    output logic                 k_gimme,
    output logic [1:0]           k_mode,
    output logic [DW-1:0]        k_in,
    input  logic                 k_ack,
    input  logic                 k_out_valid,
    input  logic                 k_out_buf_empty,
    input  logic [DW-1:0]        k_out
`ifdef KECCAK_ARB_WDOG_EN
    ,
    output logic                 wdog_err
`endif
);

    localparam int IW = $clog2(NREQ);

    arb_state_t    state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] gidx;
    logic [1:0]    mode_q;
    logic [NREQ-1:0] win_onehot;
    logic [IW-1:0] win_idx;
    logic          win_any;
    logic          wdog_fire;

    if (NREQ < 2 || NREQ > 8 || WDOG_CYCLES < 1) begin : g_bad_params
        $error("keccak_arbiter: NREQ must be 2..8 and WDOG_CYCLES must be positive");
    end

    rr_arbiter #(
        .NREQ(NREQ),
        .IW  (IW)
    ) u_rr (
        .req       (req),
        .ptr       (ptr),
        .win_onehot(win_onehot),
        .win_idx   (win_idx),
        .win_any   (win_any)
    );

    assign busy   = (state != IDLE);
    assign k_mode = mode_q;

    // Ownership FSM; a release always drains the core before re-arbitrating
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            grant        <= '0;
            gidx         <= '0;
            ptr          <= IW'(NREQ - 1);
            mode_q       <= '0;
            k_start_calc <= 1'b0;
        end else begin
            k_start_calc <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_any) begin
                        grant        <= win_onehot;
                        gidx         <= win_idx;
                        ptr          <= win_idx;
                        mode_q       <= req_mode[2*int'(win_idx) +: 2];
                        k_start_calc <= 1'b1;
                        state        <= START;
                    end
                end
                START: state <= OWN;
                OWN: begin
                    if (req_release[gidx] || wdog_fire) begin
                        grant <= '0;
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (k_out_buf_empty) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        k_in          = '0;
        k_in_valid    = 1'b0;
        k_is_last     = 1'b0;
        k_gimme       = 1'b0;
        req_ack       = '0;
        req_out_valid = '0;
        req_out       = '0;
        if (state == OWN) begin
            k_in                = req_in[int'(gidx)*DW +: DW];
            k_in_valid          = req_in_valid[gidx];
            k_is_last           = req_is_last[gidx];
            k_gimme             = req_gimme[gidx];
            req_ack[gidx]       = k_ack;
            req_out_valid[gidx] = k_out_valid;
            req_out             = k_out;
        end else if (state == FLUSH) begin
            // Only squeeze while words remain, so an empty core is never popped
            k_gimme = !k_out_buf_empty;
        end
    end

`ifdef KECCAK_ARB_WDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);

    logic [WW-1:0] wdog_cnt;
    logic          owner_active;

    assign owner_active = req_in_valid[gidx] | req_gimme[gidx] | k_out_valid;
    assign wdog_fire    = (state == OWN) && !owner_active &&
                          (wdog_cnt == WW'(WDOG_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_cnt <= '0;
            wdog_err <= 1'b0;
        end else if (state != OWN || owner_active) begin
            wdog_cnt <= '0;
        end else if (wdog_fire) begin
            wdog_cnt <= '0;
            wdog_err <= 1'b1;
        end else begin
            wdog_cnt <= wdog_cnt + WW'(1);
        end
    end
`else
    assign wdog_fire = 1'b0;
`endif

endmodule

// File: doc/keccak_arbiter.md
Name: keccak_arbiter

Overview:
- Shares one keccak core among NREQ requesters (e.g. matrix-A SHAKE128 parse, CBD SHAKE256 PRF, G/H hashing).
- Round-robin grant; the owner keeps the core from grant until it pulses release.
- Issues the one-cycle start_calc and mode for each new owner, muxes the absorb/squeeze handshakes, and demuxes core output.
- Drains stale output words before handing the core to the next owner.

Parameters:
- NREQ, 3, number of requesters (2..8)
- DW, 64, seed/output word width
- WDOG_CYCLES, 1024, watchdog limit (used only with optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req  in  NREQ  request core, level
- req_release  in  NREQ  one-cycle pulse: owner finished
- req_mode  in  2*NREQ  mode per requester (0 SHA3-256, 1 SHA3-512, 2 SHAKE128, 3 SHAKE256)
- req_in  in  DW*NREQ  seed word per requester
- req_in_valid  in  NREQ  seed word valid
- req_is_last  in  NREQ  last seed word
- req_gimme  in  NREQ  output read/squeeze request
- grant  out  NREQ  one-hot owner
- req_ack  out  NREQ  core ack routed to owner
- req_out_valid  out  NREQ  core out_valid routed to owner
- req_out  out  DW  core output word, broadcast
- busy  out  1  state != IDLE
- k_start_calc, k_in_valid, k_is_last, k_gimme  out  1  core controls
- k_mode  out  2  core mode
- k_in  out  DW  core seed word
- k_ack, k_out_valid, k_out_buf_empty  in  1  core status
- k_out  in  DW  core output word

Behaviour:
- FSM states: IDLE, START, OWN, FLUSH. Reset or mid-operation rst forces IDLE and sets ptr=NREQ-1, so index 0 wins first. All outputs reset to 0.
- Round-robin rule: the winner is the first set req bit strictly after ptr, with wrap-around.
- IDLE: if any req, register grant=winner, ptr=winner index, mode_q=req_mode[winner]; go to START.
- START (exactly 1 cycle): k_start_calc=1, k_mode=mode_q; go to OWN. Latency from req seen in IDLE to k_start_calc is 1 cycle.
- OWN routing is combinational for the granted index g:
  - k_in=req_in[g], k_in_valid=req_in_valid[g], k_is_last=req_is_last[g], k_gimme=req_gimme[g].
  - req_ack[g]=k_ack, req_out_valid[g]=k_out_valid.
  - All non-granted ack and out_valid bits are 0.
- k_mode holds mode_q from START until the next grant.
- req_release[g] in OWN: clear grant next cycle and go to FLUSH. Release from a non-owner is ignored. The owner dropping req without release does not end ownership.
- FLUSH:
  - k_gimme=1 while k_out_buf_empty=0; popped words are discarded and no req_out_valid is raised.
  - When k_out_buf_empty=1, go to IDLE.
  - k_gimme is never asserted while the core buffer is empty, so no spurious squeeze occurs.
- Release coinciding with a new req: release is processed first; the new req is arbitrated in IDLE after FLUSH. There is no bypass of FLUSH.
- Request inputs are ignored outside OWN, except req used for arbitration in IDLE.

Optional Feature:
- Macro KECCAK_ARB_WDOG_EN.
- When defined:
  - A counter runs in OWN and clears on any owner in_valid, gimme or k_out_valid.
  - On reaching WDOG_CYCLES it forces release: the FSM goes to FLUSH and output wdog_err (1 bit) is set sticky until rst.
- When undefined: no counter, no wdog_err port, and ownership ends only by release.

Decomposition:
- Package keccak_arb_pkg:
  - State enum.
  - Mode constants SHA3_256=0, SHA3_512=1, SHAKE128=2, SHAKE256=3.
  - Output words per mode: 4, 8, 21, 17.
- Sub-module rr_arbiter: combinational winner select from req and ptr, one-hot out plus index out; instantiated once.

Test Plan:
- After reset, req=3'b001, mode0=2 -> grant=001 at cycle 1, k_start_calc pulse at cycle 1 with k_mode=2, routing active from cycle 2.
- req=3'b111 held; each owner releases after its hash -> grant sequence 001, 010, 100, 001; no two grants overlap.
- Owner 1 absorbs a 34-word SHAKE128 seed and squeezes 21 words -> req_ack and req_out_valid appear only on bit 1, and k_in equals req_in[1] each cycle.
- Release with 5 words left in the core FIFO -> FLUSH issues exactly 5 k_gimme cycles with req_out_valid=0, then IDLE.
- Release from a non-owner during OWN -> ignored and grant unchanged; rst asserted in OWN -> all outputs 0 immediately and the next grant goes to index 0.
- With KECCAK_ARB_WDOG_EN and WDOG_CYCLES=16, owner stalls -> forced FLUSH after 16 idle cycles, wdog_err=1 and sticky.
